// File: rtl/uart_word_assembler_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_word_assembler_if
// Purpose  : Bundles the signals of the UART word assembler: the bit-serial
//            feed from the UART receiver, the word hand-off to the consumer
//            and the optional echo path to the UART transmitter.
// Ports    : none (signal bundle only)
//   rx_bit/rx_ready        : received bit and its one-cycle strobe
//   flush/clr_ovr          : partial-word discard, sticky overrun clear
//   word_data/word_valid/word_ready : word hand-off to the consumer
//   bit_cnt/overrun        : status
//   tx_start/tx_data/tx_ready       : echo byte to the UART transmitter
// Modports : slave  = the assembler itself
//            master = the environment around it (UART + consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_word_assembler_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W)
);
  logic              rx_bit;
  logic              rx_ready;
  logic              flush;
  logic              clr_ovr;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  bit_cnt;
  logic              overrun;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;

  modport slave (
    input  rx_bit, rx_ready, flush, clr_ovr, word_ready, tx_ready,
    output word_data, word_valid, bit_cnt, overrun, tx_start, tx_data
  );

  modport master (
    output rx_bit, rx_ready, flush, clr_ovr, word_ready, tx_ready,
    input  word_data, word_valid, bit_cnt, overrun, tx_start, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_word_assembler
// Purpose  : Packs the LSB-first bit stream of a UART receiver into WORD_W-bit
//            operand words, with one holding register towards the consumer,
//            a sticky overrun flag and a flush for frame resynchronisation.
// Ports    :
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_word_assembler_if.slave (see interface file for signals)
// Options  : define UART_WORD_ASM_ECHO_EN to add a byte-granular echo of the
//            received stream to the UART transmitter (tx_start/tx_data);
//            without it tx_start/tx_data are constant 0 and tx_ready unused.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_assembler #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(WORD_W)
) (
  input wire clk,
  input wire rst_n,
  uart_word_assembler_if.slave bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  // Bit 0 of the shift register would be shifted out by the very next bit,
  // so only the upper WORD_W-1 bits are stored between strobes.
  logic [WORD_W-1:1] sreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  hold_state_e       state_q;
  logic [WORD_W-1:0] word_data_q;
  logic              overrun_q;

  logic              w_strobe;
  logic              w_complete;
  logic [WORD_W-1:0] w_shift;

  // flush beats a coincident strobe, so a flushed bit is never counted
  assign w_strobe   = bus.rx_ready & ~bus.flush;
  assign w_complete = w_strobe & (bit_cnt_q == LAST_BIT);
  assign w_shift    = {bus.rx_bit, sreg_q};

  // --------------------------------------------------------------------------
  // Collect: shift register and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else if (bus.flush) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else if (bus.rx_ready) begin
      sreg_q    <= w_shift[WORD_W-1:1];
      bit_cnt_q <= w_complete ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Holding register FSM and sticky overrun
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      word_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (w_complete) begin
            word_data_q <= w_shift;
            state_q     <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_complete && bus.word_ready) begin
            // hand-off and reload in one cycle: word_valid has no gap
            word_data_q <= w_shift;
          end else if (w_complete) begin
            // consumer still owns the old word: the new one is lost
            overrun_q <= 1'b1;
          end else if (bus.word_ready) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase

      // a lost word in the same cycle as clr_ovr must stay visible
      if (!(state_q == S_FULL && w_complete && !bus.word_ready) && bus.clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.word_data  = word_data_q;
  assign bus.word_valid = (state_q == S_FULL);
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.overrun    = overrun_q;

  // --------------------------------------------------------------------------
  // Optional byte echo towards the UART transmitter
  // --------------------------------------------------------------------------
`ifdef UART_WORD_ASM_ECHO_EN
  logic       pend_q;
  logic [7:0] pend_byte_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;
  logic       w_byte_done;
  logic       w_issue;

  // Byte boundaries follow the word bit counter; the 8 newest bits sit at
  // the top of the shift value with the newest one as byte bit 7.
  assign w_byte_done = w_strobe & (bit_cnt_q[2:0] == 3'd7);
  assign w_issue     = pend_q & bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_start_q <= w_issue;
      if (w_issue) begin
        tx_data_q <= pend_byte_q;
      end
      // a fresh byte takes the single pending slot even while the old one is
      // being issued, and simply overwrites an unissued one
      if (w_byte_done) begin
        pend_q      <= 1'b1;
        pend_byte_q <= w_shift[WORD_W-1 -: 8];
      end else if (bus.flush || w_issue) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
`else
  logic w_unused_tx_ready;

  assign w_unused_tx_ready = bus.tx_ready;
  assign bus.tx_start      = 1'b0;
  assign bus.tx_data       = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_word_assembler
// Purpose  : Self-checking bench for uart_word_assembler with WORD_W=16.
//            A table of words drives the main collect/hold/overrun behaviour;
//            hand-written sequences cover flush, async reset and echo.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_assembler;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_word_assembler_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  uart_word_assembler #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] word;
    logic        pre_clr;      // pulse clr_ovr before sending
    logic        pre_consume;  // take the held word before sending
    logic        ready_last;   // word_ready together with the last strobe
    logic        valid_before; // word_valid expected just before last strobe
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_ovr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_bit   = b;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_bit   = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic consume();
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  // counts tx_start pulses over a window and keeps the data of the last one
  task automatic watch_tx(input int cycles, output int pulses, output logic [7:0] data);
    pulses = 0;
    data   = 8'h00;
    for (int i = 0; i < cycles; i++) begin
      if (bus.tx_start === 1'b1) begin
        pulses++;
        data = bus.tx_data;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [15:0] w;
    logic [7:0]  b;
    int          pulses;
    logic [7:0]  tdata;

    //          word     clr   cons  rdyL  vBef  data     vld   ovr
    vecs[0] = '{16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b1};
    vecs[2] = '{16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0};
    vecs[3] = '{16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    vecs[4] = '{16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0F0F, 1'b1, 1'b0};

    bus.rx_bit     = 1'b0;
    bus.rx_ready   = 1'b0;
    bus.flush      = 1'b0;
    bus.clr_ovr    = 1'b0;
    bus.word_ready = 1'b0;
    bus.tx_ready   = 1'b0;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset word_data",  32'(bus.word_data),  32'h0);
    chk("reset word_valid", 32'(bus.word_valid), 32'h0);
    chk("reset bit_cnt",    32'(bus.bit_cnt),    32'h0);
    chk("reset overrun",    32'(bus.overrun),    32'h0);
    chk("reset tx_start",   32'(bus.tx_start),   32'h0);
    chk("reset tx_data",    32'(bus.tx_data),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven words ----------------
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].pre_clr) begin
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        chk($sformatf("v%0d clr_ovr", v), 32'(bus.overrun), 32'h0);
      end
      if (vecs[v].pre_consume) begin
        consume();
        chk($sformatf("v%0d consume", v), 32'(bus.word_valid), 32'h0);
      end
      send_bits(vecs[v].word, 15);
      chk($sformatf("v%0d bit_cnt 15", v), 32'(bus.bit_cnt), 32'd15);
      chk($sformatf("v%0d valid before", v), 32'(bus.word_valid), 32'(vecs[v].valid_before));
      w = vecs[v].word;
      bus.word_ready = vecs[v].ready_last;
      send_bit(w[15]);
      bus.word_ready = 1'b0;
      chk($sformatf("v%0d word_data", v),  32'(bus.word_data),  32'(vecs[v].exp_data));
      chk($sformatf("v%0d word_valid", v), 32'(bus.word_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d overrun", v),    32'(bus.overrun),    32'(vecs[v].exp_ovr));
      chk($sformatf("v%0d bit_cnt wrap", v), 32'(bus.bit_cnt),  32'h0);
    end

    // ---------------- word_ready while empty ----------------
    consume();
    chk("take 0F0F valid", 32'(bus.word_valid), 32'h0);
    consume();
    chk("ready empty valid", 32'(bus.word_valid), 32'h0);
    chk("ready empty data",  32'(bus.word_data),  32'h0F0F);

    // ---------------- flush of a partial word ----------------
    send_bits(16'hFFFF, 5);
    chk("partial bit_cnt", 32'(bus.bit_cnt), 32'd5);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush bit_cnt", 32'(bus.bit_cnt), 32'h0);
    send_bits(16'h8001, 16);
    chk("after flush data",  32'(bus.word_data),  32'h8001);
    chk("after flush valid", 32'(bus.word_valid), 32'h1);

    // ---------------- flush coincident with a strobe ----------------
    send_bits(16'h0007, 3);
    chk("pre coincident bit_cnt", 32'(bus.bit_cnt), 32'd3);
    bus.rx_bit   = 1'b1;
    bus.rx_ready = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_bit   = 1'b0;
    bus.flush    = 1'b0;
    chk("coincident flush bit_cnt", 32'(bus.bit_cnt),    32'h0);
    chk("flush keeps valid",        32'(bus.word_valid), 32'h1);
    chk("flush keeps data",         32'(bus.word_data),  32'h8001);

    // ---------------- overrun set beats clr_ovr ----------------
    w = 16'hCAFE;
    send_bits(w, 15);
    bus.clr_ovr = 1'b1;
    send_bit(w[15]);
    bus.clr_ovr = 1'b0;
    chk("ovr priority overrun", 32'(bus.overrun),   32'h1);
    chk("ovr priority data",    32'(bus.word_data), 32'h8001);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    chk("clr_ovr alone", 32'(bus.overrun), 32'h0);

    consume();
    send_bits(16'h1357, 16);
    chk("aligned after flush data", 32'(bus.word_data), 32'h1357);

    // ---------------- asynchronous reset mid-word ----------------
    send_bits(16'h01FF, 9);
    chk("pre reset bit_cnt", 32'(bus.bit_cnt),    32'd9);
    chk("pre reset valid",   32'(bus.word_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async word_valid", 32'(bus.word_valid), 32'h0);
    chk("async word_data",  32'(bus.word_data),  32'h0);
    chk("async bit_cnt",    32'(bus.bit_cnt),    32'h0);
    chk("async overrun",    32'(bus.overrun),    32'h0);
    chk("async tx_start",   32'(bus.tx_start),   32'h0);
    chk("async tx_data",    32'(bus.tx_data),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post reset bit_cnt", 32'(bus.bit_cnt), 32'h0);

    // ---------------- echo ----------------
`ifdef UART_WORD_ASM_ECHO_EN
    bus.tx_ready = 1'b1;
    b = 8'h5A;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    chk("echo start latency", 32'(bus.tx_start), 32'h0);
    watch_tx(6, pulses, tdata);
    chk("echo 5A pulses", 32'(pulses), 32'd1);
    chk("echo 5A data",   32'(tdata),  32'h5A);

    bus.tx_ready = 1'b0;
    b = 8'h11;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    b = 8'h22;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    watch_tx(4, pulses, tdata);
    chk("echo held pulses", 32'(pulses), 32'd0);
    bus.tx_ready = 1'b1;
    watch_tx(6, pulses, tdata);
    chk("echo overwrite pulses", 32'(pulses), 32'd1);
    chk("echo overwrite data",   32'(tdata),  32'h22);
`else
    bus.tx_ready = 1'b1;
    b = 8'h5A;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    watch_tx(6, pulses, tdata);
    chk("no echo pulses",  32'(pulses),      32'd0);
    chk("no echo tx_data", 32'(bus.tx_data), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Sits directly downstream of the UART receiver. Consumes its bit-serial output (rx_bit qualified by the one-cycle rx_ready strobe, LSB first) and packs the bits into WORD_W-bit operand words for the RSA datapath.
- Has one holding register, so the next word can be collected while the consumer still owns the previous one.
- Flags overrun, and supports a flush to resynchronise between frames.

Parameters:
- WORD_W, 32, operand word width in bits; must be a multiple of 8 and at least 8.
- CNT_W, $clog2(WORD_W), width of the bit counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_bit  in  1  received bit from the UART; valid only when rx_ready=1.
- rx_ready  in  1  one-cycle strobe, one per received bit.
- flush  in  1  synchronous; discards the partial word and zeroes the bit counter.
- clr_ovr  in  1  synchronous; clears the sticky overrun flag.
- word_data  out  WORD_W  assembled word; stable while word_valid=1.
- word_valid  out  1  word_data holds an untaken word.
- word_ready  in  1  consumer accepts; transfer happens when word_valid & word_ready.
- bit_cnt  out  CNT_W  bits collected into the current partial word.
- overrun  out  1  sticky; a completed word was lost.
- tx_start  out  1  echo byte strobe (ECHO feature; tied 0 without it).
- tx_data  out  8  echo byte (ECHO feature; tied 0 without it).
- tx_ready  in  1  UART transmitter idle (ECHO feature; ignored without it).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - shift register, word_data, bit_cnt, tx_data = 0;
  - word_valid, overrun, tx_start = 0.
  - Reset mid-word discards the partial word with no output.
- Collect:
  - On rx_ready: sreg <= {rx_bit, sreg[WORD_W-1:1]}; bit_cnt increments.
  - The first received bit ends in word bit 0.
- Completion (rx_ready with bit_cnt==WORD_W-1):
  - bit_cnt wraps to 0.
  - Candidate word = {rx_bit, sreg[WORD_W-1:1]}.
- Holding register is a two-state FSM, EMPTY and FULL; word_valid = (state==FULL).
  - EMPTY + completion: load word_data; go FULL. word_valid rises the cycle after the last bit strobe (latency 1).
  - FULL + transfer, no completion: go EMPTY.
  - FULL + completion + transfer in the same cycle: load the new word; stay FULL; word_valid stays 1 with no gap.
  - FULL + completion, no transfer: new word dropped; word_data unchanged; overrun <= 1.
- word_data changes only on a load. The consumer may sample it at any cycle while word_valid=1.
- word_ready while EMPTY: no effect.
- flush:
  - Zeroes bit_cnt and sreg. A coincident rx_ready is discarded (flush wins).
  - Does not touch the holding register, word_valid or overrun.
- overrun: set has priority over clr_ovr in the same cycle; it is cleared only by clr_ovr or reset.
- No combinational path from any input to any output.

Optional Feature:
- Macro: UART_WORD_ASM_ECHO_EN.
- Defined: byte-granular echo back to the UART transmitter.
  - Every rx_ready with bit_cnt[2:0]==7 (not flushed) completes a byte, which is latched into a one-entry pending buffer as the 8 most recent bits in arrival order (LSB-first byte).
  - When pending & tx_ready: tx_data <= byte, tx_start = 1 for exactly one cycle, pending cleared.
  - A new byte completing while pending overwrites the pending byte.
  - Completion and issue in the same cycle: the old byte is issued, the new byte becomes pending.
  - flush clears pending.
- Undefined: the echo logic is absent; tx_start=0 and tx_data=0 constantly; tx_ready is unused.

Test Plan:
- WORD_W=16. Reset, then 16 strobes of 16'hA5C3 LSB first with word_ready=0 → word_valid=1 one cycle after the 16th strobe, word_data=16'hA5C3, bit_cnt=0, overrun=0.
- Hold word_ready=0 and send a second word 16'h1234 → word_data stays 16'hA5C3, overrun=1. Pulse clr_ovr → overrun=0.
- Word 16'h00FF pending; 16'hBEEF's last strobe coincides with word_ready=1 → word_valid never drops; word_data=16'hBEEF the next cycle; overrun=0.
- Send 5 bits, flush, then 16 bits of 16'h8001 → word_data=16'h8001. Flush coincident with a strobe → bit_cnt=0 and the bit is ignored.
- Assert rst_n=0 asynchronously mid-word (bit_cnt=9, word_valid=1) → all outputs 0 immediately, without waiting for a clock edge.
- UART_WORD_ASM_ECHO_EN with tx_ready=1: send byte 8'h5A → tx_start pulses once, tx_data=8'h5A. With tx_ready=0, send 8'h11 then 8'h22, then raise tx_ready → a single tx_start with tx_data=8'h22.
